// File: rtl/dpram_port_arb.sv
// Three-requester round-robin arbiter in front of a single byte-enabled RAM port,
// with per-requester bus locking bounded by LOCK_MAX consecutive grants.
module dpram_port_arb #(
    parameter int AW       = 12,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [2:0]    req,
    input  logic [2:0]    lock,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [31:0]   wdata0,
    input  logic [31:0]   wdata1,
    input  logic [31:0]   wdata2,
    input  logic [3:0]    we0,
    input  logic [3:0]    we1,
    input  logic [3:0]    we2,
    output logic [2:0]    gnt,
    output logic [2:0]    ack,
    output logic [31:0]   rdata,
    output logic          lock_err,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_din,
    output logic [3:0]    mem_we,
    input  logic [31:0]   mem_dout
);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t      state, state_nxt;
    logic [1:0]  ptr, ptr_nxt;
    logic [1:0]  owner, owner_nxt;
    logic [4:0]  lock_cnt, lock_cnt_nxt;
    logic [4:0]  cnt_inc;
    logic        no_relock, no_relock_nxt;
    logic        lock_err_nxt;
    logic [2:0]  gnt_c;
    logic [1:0]  c0, c1, c2;
    logic [1:0]  win;
    logic        win_vld;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign c0      = ptr;
    assign c1      = inc3(ptr);
    assign c2      = inc3(c1);
    assign cnt_inc = lock_cnt + 5'd1;

    always_comb begin
        win_vld = 1'b1;
        win     = c0;
        if (req[c0])      win = c0;
        else if (req[c1]) win = c1;
        else if (req[c2]) win = c2;
        else              win_vld = 1'b0;
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        owner_nxt     = owner;
        lock_cnt_nxt  = lock_cnt;
        no_relock_nxt = no_relock;
        lock_err_nxt  = 1'b0;
        gnt_c         = 3'b000;
        case (state)
            ARB: begin
                if (win_vld) begin
                    gnt_c[win] = 1'b1;
                    ptr_nxt    = inc3(win);
                    // A broken lock gets exactly one unlocked grant before it may lock again
                    if (no_relock && win == owner) begin
                        no_relock_nxt = 1'b0;
                    end else if (lock[win]) begin
                        owner_nxt     = win;
                        no_relock_nxt = 1'b0;
                        if (LOCK_MAX == 1) begin
                            lock_err_nxt  = 1'b1;
                            no_relock_nxt = 1'b1;
                        end else begin
                            state_nxt    = LOCKED;
                            lock_cnt_nxt = 5'd1;
                        end
                    end
                end
            end
            LOCKED: begin
                if (req[owner]) gnt_c[owner] = 1'b1;
                if (!req[owner] || !lock[owner]) begin
                    state_nxt    = ARB;
                    ptr_nxt      = inc3(owner);
                    lock_cnt_nxt = 5'd0;
                end else if (cnt_inc == 5'(LOCK_MAX)) begin
                    state_nxt     = ARB;
                    ptr_nxt       = inc3(owner);
                    lock_cnt_nxt  = 5'd0;
                    lock_err_nxt  = 1'b1;
                    no_relock_nxt = 1'b1;
                end else begin
                    lock_cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= ARB;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            lock_cnt  <= 5'd0;
            no_relock <= 1'b0;
            ack       <= 3'b000;
            lock_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            lock_cnt  <= lock_cnt_nxt;
            no_relock <= no_relock_nxt;
            ack       <= gnt;
            lock_err  <= lock_err_nxt;
        end
    end

    // Grant is combinational, so it is gated directly by reset
    assign gnt    = rst_b ? gnt_c : 3'b000;
    assign mem_en = |gnt;
    assign rdata  = mem_dout;

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = '0;
        case (gnt)
            3'b001: begin mem_addr = addr0; mem_din = wdata0; mem_we = we0; end
            3'b010: begin mem_addr = addr1; mem_din = wdata1; mem_we = we1; end
            3'b100: begin mem_addr = addr2; mem_din = wdata2; mem_we = we2; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dpram_port_arb.sv
// Scoreboard bench for dpram_port_arb: per-cycle grant checks, queued ack/rdata/lock_err checks.
module tb_dpram_port_arb;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [2:0]    req, lock;
    logic [AW-1:0] addr0, addr1, addr2;
    logic [31:0]   wdata0, wdata1, wdata2;
    logic [3:0]    we0, we1, we2;
    logic [2:0]    gnt, ack;
    logic [31:0]   rdata;
    logic          lock_err, mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din, mem_dout;
    logic [3:0]    mem_we;

    logic [31:0]   ram [0:(1<<AW)-1];

    typedef struct {
        logic [2:0]  gnt;
        bit          crd;
        logic [31:0] rd;
        bit          le;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;

    dpram_port_arb #(.AW(AW), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .lock(lock),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .we0(we0), .we1(we1), .we2(we2),
        .gnt(gnt), .ack(ack), .rdata(rdata), .lock_err(lock_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_we(mem_we), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Registered-read, read-before-write byte-enabled RAM
    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] r, input logic [2:0] l,
                        input logic [2:0] eg, input bit crd = 0,
                        input logic [31:0] rd = 0, input bit le = 0);
        sb_t           e;
        logic [AW-1:0] ea;
        logic [3:0]    ew;
        req  = r;
        lock = l;
        @(negedge clk);
        ea = '0;
        ew = '0;
        case (eg)
            3'b001: begin ea = addr0; ew = we0; end
            3'b010: begin ea = addr1; ew = we1; end
            3'b100: begin ea = addr2; ew = we2; end
            default: ;
        endcase
        chk({tag, ":gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ":mem_en"}, 32'(mem_en), 32'(|eg));
        chk({tag, ":mem_addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, ":mem_we"}, 32'(mem_we), 32'(ew));
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, ":ack"}, 32'(ack), 32'(e.gnt));
            chk({tag, ":lock_err"}, 32'(lock_err), 32'(e.le));
            if (e.crd) chk({tag, ":rdata"}, rdata, e.rd);
        end
        e.gnt = eg; e.crd = crd; e.rd = rd; e.le = le;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic sb_reset();
        sb_t e;
        sbq.delete();
        e.gnt = 3'b000; e.crd = 0; e.rd = '0; e.le = 0;
        sbq.push_back(e);
    endtask

    initial begin
        rst_b = 1'b0;
        req = 3'b111; lock = 3'b000;
        addr0 = '0; addr1 = '0; addr2 = '0;
        wdata0 = '0; wdata1 = '0; wdata2 = '0;
        we0 = '0; we1 = '0; we2 = '0;
        repeat (2) @(negedge clk);
        chk("rst:gnt", 32'(gnt), 0);
        chk("rst:mem_en", 32'(mem_en), 0);
        chk("rst:ack", 32'(ack), 0);
        chk("rst:lock_err", 32'(lock_err), 0);
        sb_reset();
        @(posedge clk); #1;
        rst_b = 1'b1;

        // round robin
        step("rr0", 3'b111, 3'b000, 3'b001);
        step("rr1", 3'b111, 3'b000, 3'b010);
        step("rr2", 3'b111, 3'b000, 3'b100);
        step("rr3", 3'b111, 3'b000, 3'b001);
        step("rr4", 3'b111, 3'b000, 3'b010);
        step("rr5", 3'b111, 3'b000, 3'b100);

        // write then read-back latency
        addr0 = 12'd5; wdata0 = 32'hA5A5_0001; we0 = 4'hF;
        step("wr5", 3'b001, 3'b000, 3'b001);
        we0 = 4'h0; wdata0 = '0;
        step("rd5", 3'b001, 3'b000, 3'b001, 1, 32'hA5A5_0001);
        step("idle0", 3'b000, 3'b000, 3'b000);

        // byte write merge
        addr0 = 12'd7; wdata0 = 32'h1122_3344; we0 = 4'hF;
        step("wr7", 3'b001, 3'b000, 3'b001);
        we0 = 4'h0;
        addr1 = 12'd7; wdata1 = 32'hFFFF_FFFF; we1 = 4'b0010;
        step("bw7", 3'b010, 3'b000, 3'b010);
        we1 = 4'h0;
        addr2 = 12'd7;
        step("rd7", 3'b100, 3'b000, 3'b100, 1, 32'h1122_FF44);
        step("idle1", 3'b000, 3'b000, 3'b000);

        // normal lock and release
        addr0 = 12'd1; addr1 = 12'd2; addr2 = 12'd3;
        step("lk_pre", 3'b001, 3'b000, 3'b001);
        step("lk0", 3'b111, 3'b010, 3'b010);
        step("lk1", 3'b111, 3'b010, 3'b010);
        step("lk2", 3'b111, 3'b010, 3'b010);
        step("lk_rel", 3'b111, 3'b000, 3'b010);
        step("lk_a", 3'b111, 3'b000, 3'b100);
        step("lk_b", 3'b111, 3'b000, 3'b001);

        // forced break at LOCK_MAX=4
        step("br_pre", 3'b010, 3'b000, 3'b010);
        step("br0", 3'b101, 3'b100, 3'b100);
        step("br1", 3'b101, 3'b100, 3'b100);
        step("br2", 3'b101, 3'b100, 3'b100);
        step("br3", 3'b101, 3'b100, 3'b100, 0, 0, 1);
        step("br4", 3'b101, 3'b100, 3'b001);
        step("br5", 3'b101, 3'b100, 3'b100);
        step("br6", 3'b101, 3'b100, 3'b001);
        step("idle2", 3'b000, 3'b000, 3'b000);

        // reset while locked
        step("rl0", 3'b010, 3'b010, 3'b010);
        step("rl1", 3'b111, 3'b010, 3'b010);
        rst_b = 1'b0;
        #1;
        chk("rl:gnt_now", 32'(gnt), 0);
        chk("rl:ack_now", 32'(ack), 0);
        chk("rl:lock_err_now", 32'(lock_err), 0);
        sb_reset();
        @(posedge clk); #1;
        step("rl_r0", 3'b111, 3'b010, 3'b000);
        step("rl_r1", 3'b111, 3'b010, 3'b000);
        rst_b = 1'b1;
        step("rl_post", 3'b111, 3'b000, 3'b001);
        step("idle3", 3'b000, 3'b000, 3'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
